// File: rtl/ctrl_pipe_hazard.sv
// Pipeline control carrier: moves decoded controls ID->EX->MEM->WB, detects load-use
// hazards (1-cycle stall plus bubble into EX) and resolves taken branches in EX (squashes ID).
// Latency: one cycle per stage. Backpressure: stall holds PC and IF/ID upstream; the
// EX/MEM and MEM/WB registers never stall.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   id_valid, id_*             decoded controls and register fields of the ID instruction
//   ex_zero                    ALU zero flag of the instruction currently in EX
//   stall, flush_ifid          combinational hazard/branch outputs for the front end
//   ex_*, mem_*, wb_*          registered stage controls (ID/EX, EX/MEM, MEM/WB)
//   fwd_a, fwd_b               EX operand selects: 00 regfile, 10 from MEM, 01 from WB
//   stall_cnt, flush_cnt       saturating event counters, cleared only by reset

module ctrl_pipe_hazard #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  // ID stage inputs
  input  logic             id_valid,
  input  logic [1:0]       id_ALUop,
  input  logic             id_branch,
  input  logic             id_memRead,
  input  logic             id_memtoReg,
  input  logic             id_memWrite,
  input  logic             id_ALUsrc,
  input  logic             id_regWrite,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             ex_zero,
  // hazard / branch
  output logic             stall,
  output logic             flush_ifid,
  // ID/EX
  output logic [1:0]       ex_ALUop,
  output logic             ex_branch,
  output logic             ex_memRead,
  output logic             ex_memtoReg,
  output logic             ex_memWrite,
  output logic             ex_ALUsrc,
  output logic             ex_regWrite,
  output logic [RA_W-1:0]  ex_rs1,
  output logic [RA_W-1:0]  ex_rs2,
  output logic [RA_W-1:0]  ex_rd,
  // EX/MEM
  output logic             mem_memRead,
  output logic             mem_memWrite,
  output logic             mem_memtoReg,
  output logic             mem_regWrite,
  output logic [RA_W-1:0]  mem_rd,
  // MEM/WB
  output logic             wb_memtoReg,
  output logic             wb_regWrite,
  output logic [RA_W-1:0]  wb_rd,
  // forwarding
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  // event counters
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [RA_W-1:0]  RZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ID/EX register
  logic [1:0]      ex_ALUop_q,    ex_ALUop_d;
  logic            ex_branch_q,   ex_branch_d;
  logic            ex_memRead_q,  ex_memRead_d;
  logic            ex_memtoReg_q, ex_memtoReg_d;
  logic            ex_memWrite_q, ex_memWrite_d;
  logic            ex_ALUsrc_q,   ex_ALUsrc_d;
  logic            ex_regWrite_q, ex_regWrite_d;
  logic [RA_W-1:0] ex_rs1_q,      ex_rs1_d;
  logic [RA_W-1:0] ex_rs2_q,      ex_rs2_d;
  logic [RA_W-1:0] ex_rd_q,       ex_rd_d;

  // EX/MEM register
  logic            mem_memRead_q,  mem_memRead_d;
  logic            mem_memWrite_q, mem_memWrite_d;
  logic            mem_memtoReg_q, mem_memtoReg_d;
  logic            mem_regWrite_q, mem_regWrite_d;
  logic [RA_W-1:0] mem_rd_q,       mem_rd_d;

  // MEM/WB register
  logic            wb_memtoReg_q, wb_memtoReg_d;
  logic            wb_regWrite_q, wb_regWrite_d;
  logic [RA_W-1:0] wb_rd_q,       wb_rd_d;

  // counters
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // hazard terms
  logic br_taken;
  logic hz;
  logic stall_w;
  logic load_id;

  // Hazard detection only looks at registered EX state and the ID fields, so stall and
  // flush are combinational from id_* but no id_* input reaches a stage output.
  always_comb begin
    br_taken = ex_branch_q & ex_zero;
    hz       = id_valid & ex_memRead_q & (ex_rd_q != RZERO) &
               ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));
    // A taken branch squashes the dependent instruction anyway, so it wins over the stall.
    stall_w  = hz & ~br_taken;
    load_id  = id_valid & ~stall_w & ~br_taken;
  end

  // Next-state for all pipeline registers and counters.
  always_comb begin
    // ID/EX: either the ID instruction or an all-zero bubble.
    ex_ALUop_d    = 2'b00;
    ex_branch_d   = 1'b0;
    ex_memRead_d  = 1'b0;
    ex_memtoReg_d = 1'b0;
    ex_memWrite_d = 1'b0;
    ex_ALUsrc_d   = 1'b0;
    ex_regWrite_d = 1'b0;
    ex_rs1_d      = RZERO;
    ex_rs2_d      = RZERO;
    ex_rd_d       = RZERO;
    if (load_id) begin
      ex_ALUop_d    = id_ALUop;
      ex_branch_d   = id_branch;
      ex_memRead_d  = id_memRead;
      ex_memtoReg_d = id_memtoReg;
      ex_memWrite_d = id_memWrite;
      ex_ALUsrc_d   = id_ALUsrc;
      ex_regWrite_d = id_regWrite;
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
      ex_rd_d       = id_rd;
    end

    // EX/MEM and MEM/WB always advance, even during a stall.
    mem_memRead_d  = ex_memRead_q;
    mem_memWrite_d = ex_memWrite_q;
    mem_memtoReg_d = ex_memtoReg_q;
    mem_regWrite_d = ex_regWrite_q;
    mem_rd_d       = ex_rd_q;

    wb_memtoReg_d  = mem_memtoReg_q;
    wb_regWrite_d  = mem_regWrite_q;
    wb_rd_d        = mem_rd_q;

    // Saturating event counters.
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_w && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (br_taken && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ALUop_q     <= 2'b00;
      ex_branch_q    <= 1'b0;
      ex_memRead_q   <= 1'b0;
      ex_memtoReg_q  <= 1'b0;
      ex_memWrite_q  <= 1'b0;
      ex_ALUsrc_q    <= 1'b0;
      ex_regWrite_q  <= 1'b0;
      ex_rs1_q       <= RZERO;
      ex_rs2_q       <= RZERO;
      ex_rd_q        <= RZERO;
      mem_memRead_q  <= 1'b0;
      mem_memWrite_q <= 1'b0;
      mem_memtoReg_q <= 1'b0;
      mem_regWrite_q <= 1'b0;
      mem_rd_q       <= RZERO;
      wb_memtoReg_q  <= 1'b0;
      wb_regWrite_q  <= 1'b0;
      wb_rd_q        <= RZERO;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      ex_ALUop_q     <= ex_ALUop_d;
      ex_branch_q    <= ex_branch_d;
      ex_memRead_q   <= ex_memRead_d;
      ex_memtoReg_q  <= ex_memtoReg_d;
      ex_memWrite_q  <= ex_memWrite_d;
      ex_ALUsrc_q    <= ex_ALUsrc_d;
      ex_regWrite_q  <= ex_regWrite_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
      mem_memRead_q  <= mem_memRead_d;
      mem_memWrite_q <= mem_memWrite_d;
      mem_memtoReg_q <= mem_memtoReg_d;
      mem_regWrite_q <= mem_regWrite_d;
      mem_rd_q       <= mem_rd_d;
      wb_memtoReg_q  <= wb_memtoReg_d;
      wb_regWrite_q  <= wb_regWrite_d;
      wb_rd_q        <= wb_rd_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  // Forwarding: the younger producer (MEM) holds the newer value, so it beats WB.
  // Register 0 is hardwired and must never be forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_regWrite_q && (mem_rd_q != RZERO) && (mem_rd_q == ex_rs1_q)) begin
      fwd_a = 2'b10;
    end else if (wb_regWrite_q && (wb_rd_q != RZERO) && (wb_rd_q == ex_rs1_q)) begin
      fwd_a = 2'b01;
    end
    if (mem_regWrite_q && (mem_rd_q != RZERO) && (mem_rd_q == ex_rs2_q)) begin
      fwd_b = 2'b10;
    end else if (wb_regWrite_q && (wb_rd_q != RZERO) && (wb_rd_q == ex_rs2_q)) begin
      fwd_b = 2'b01;
    end
  end

  assign stall        = stall_w;
  assign flush_ifid   = br_taken;

  assign ex_ALUop     = ex_ALUop_q;
  assign ex_branch    = ex_branch_q;
  assign ex_memRead   = ex_memRead_q;
  assign ex_memtoReg  = ex_memtoReg_q;
  assign ex_memWrite  = ex_memWrite_q;
  assign ex_ALUsrc    = ex_ALUsrc_q;
  assign ex_regWrite  = ex_regWrite_q;
  assign ex_rs1       = ex_rs1_q;
  assign ex_rs2       = ex_rs2_q;
  assign ex_rd        = ex_rd_q;

  assign mem_memRead  = mem_memRead_q;
  assign mem_memWrite = mem_memWrite_q;
  assign mem_memtoReg = mem_memtoReg_q;
  assign mem_regWrite = mem_regWrite_q;
  assign mem_rd       = mem_rd_q;

  assign wb_memtoReg  = wb_memtoReg_q;
  assign wb_regWrite  = wb_regWrite_q;
  assign wb_rd        = wb_rd_q;

  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Bench for ctrl_pipe_hazard: scenario tasks drive the ID stage; expected EX-stage words
// are queued when an instruction is driven and popped when it should appear in EX.
// A second instance with a 2-bit counter width exercises counter saturation.

module tb_ctrl_pipe_hazard;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [1:0]  id_ALUop;
  logic        id_branch, id_memRead, id_memtoReg, id_memWrite, id_ALUsrc, id_regWrite;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_zero;

  logic        stall, flush_ifid;
  logic [1:0]  ex_ALUop;
  logic        ex_branch, ex_memRead, ex_memtoReg, ex_memWrite, ex_ALUsrc, ex_regWrite;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        mem_memRead, mem_memWrite, mem_memtoReg, mem_regWrite;
  logic [4:0]  mem_rd;
  logic        wb_memtoReg, wb_regWrite;
  logic [4:0]  wb_rd;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  // outputs of the narrow-counter instance
  logic        s_stall, s_flush_ifid;
  logic [1:0]  s_ex_ALUop;
  logic        s_ex_branch, s_ex_memRead, s_ex_memtoReg, s_ex_memWrite, s_ex_ALUsrc, s_ex_regWrite;
  logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic        s_mem_memRead, s_mem_memWrite, s_mem_memtoReg, s_mem_regWrite;
  logic [4:0]  s_mem_rd;
  logic        s_wb_memtoReg, s_wb_regWrite;
  logic [4:0]  s_wb_rd;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [22:0] sb[$];
  logic [22:0] exp_w;

  always #5 clk = ~clk;

  ctrl_pipe_hazard #(.RA_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ALUop(id_ALUop),
    .id_branch(id_branch), .id_memRead(id_memRead), .id_memtoReg(id_memtoReg),
    .id_memWrite(id_memWrite), .id_ALUsrc(id_ALUsrc), .id_regWrite(id_regWrite),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_zero(ex_zero),
    .stall(stall), .flush_ifid(flush_ifid), .ex_ALUop(ex_ALUop), .ex_branch(ex_branch),
    .ex_memRead(ex_memRead), .ex_memtoReg(ex_memtoReg), .ex_memWrite(ex_memWrite),
    .ex_ALUsrc(ex_ALUsrc), .ex_regWrite(ex_regWrite), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
    .mem_memtoReg(mem_memtoReg), .mem_regWrite(mem_regWrite), .mem_rd(mem_rd),
    .wb_memtoReg(wb_memtoReg), .wb_regWrite(wb_regWrite), .wb_rd(wb_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  ctrl_pipe_hazard #(.RA_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ALUop(id_ALUop),
    .id_branch(id_branch), .id_memRead(id_memRead), .id_memtoReg(id_memtoReg),
    .id_memWrite(id_memWrite), .id_ALUsrc(id_ALUsrc), .id_regWrite(id_regWrite),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_zero(ex_zero),
    .stall(s_stall), .flush_ifid(s_flush_ifid), .ex_ALUop(s_ex_ALUop), .ex_branch(s_ex_branch),
    .ex_memRead(s_ex_memRead), .ex_memtoReg(s_ex_memtoReg), .ex_memWrite(s_ex_memWrite),
    .ex_ALUsrc(s_ex_ALUsrc), .ex_regWrite(s_ex_regWrite), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2),
    .ex_rd(s_ex_rd), .mem_memRead(s_mem_memRead), .mem_memWrite(s_mem_memWrite),
    .mem_memtoReg(s_mem_memtoReg), .mem_regWrite(s_mem_regWrite), .mem_rd(s_mem_rd),
    .wb_memtoReg(s_wb_memtoReg), .wb_regWrite(s_wb_regWrite), .wb_rd(s_wb_rd),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Instruction word: {ALUop[1:0], branch, memRead, memtoReg, memWrite, ALUsrc, regWrite, rs1, rs2, rd}
  function automatic logic [22:0] ins(input logic [1:0] op, input logic [5:0] ctl,
                                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
    return {op, ctl, r1, r2, d};
  endfunction
  function automatic logic [22:0] LW(input logic [4:0] r1, input logic [4:0] d);
    return ins(2'b00, 6'b011011, r1, 5'd0, d);
  endfunction
  function automatic logic [22:0] ADD(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
    return ins(2'b10, 6'b000001, r1, r2, d);
  endfunction
  function automatic logic [22:0] BEQ(input logic [4:0] r1, input logic [4:0] r2);
    return ins(2'b01, 6'b100000, r1, r2, 5'd0);
  endfunction

  function automatic logic [22:0] ex_word();
    return {ex_ALUop, ex_branch, ex_memRead, ex_memtoReg, ex_memWrite, ex_ALUsrc, ex_regWrite,
            ex_rs1, ex_rs2, ex_rd};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [22:0] w);
    id_valid = v;
    {id_ALUop, id_branch, id_memRead, id_memtoReg, id_memWrite, id_ALUsrc, id_regWrite,
     id_rs1, id_rs2, id_rd} = w;
  endtask

  task automatic do_reset();
    set_id(1'b0, 23'd0);
    ex_zero = 1'b0;
    reset   = 1'b1;
    step();
    step();
    reset   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (ex_word() !== 23'd0) begin n_err++; $display("FAIL rst_ex: got %h want 0", ex_word()); end
    n_vec++; if ({mem_memRead, mem_memWrite, mem_memtoReg, mem_regWrite, mem_rd} !== 9'd0) begin
      n_err++; $display("FAIL rst_mem: got %h want 0", {mem_memRead, mem_memWrite, mem_memtoReg, mem_regWrite, mem_rd}); end
    n_vec++; if ({wb_memtoReg, wb_regWrite, wb_rd} !== 7'd0) begin
      n_err++; $display("FAIL rst_wb: got %h want 0", {wb_memtoReg, wb_regWrite, wb_rd}); end
    n_vec++; if ({stall, flush_ifid, fwd_a, fwd_b} !== 6'd0) begin
      n_err++; $display("FAIL rst_comb: got %b want 000000", {stall, flush_ifid, fwd_a, fwd_b}); end
    n_vec++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || s_stall_cnt !== 2'd0) begin
      n_err++; $display("FAIL rst_cnt: got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, s_stall_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, LW(5'd1, 5'd5)); sb.push_back(LW(5'd1, 5'd5));
    step();
    exp_w = sb.pop_front();
    n_vec++; if (ex_word() !== exp_w) begin n_err++; $display("FAIL lu_lw_ex: got %h want %h", ex_word(), exp_w); end
    set_id(1'b1, ADD(5'd5, 5'd2, 5'd6));
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall_on: got %b want 1", stall); end
    sb.push_back(23'd0);
    step();
    exp_w = sb.pop_front();
    n_vec++; if (ex_word() !== exp_w) begin n_err++; $display("FAIL lu_bubble: got %h want %h", ex_word(), exp_w); end
    n_vec++; if ({mem_memRead, mem_rd} !== {1'b1, 5'd5}) begin
      n_err++; $display("FAIL lu_mem_adv: got %h want %h", {mem_memRead, mem_rd}, {1'b1, 5'd5}); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_1cyc: got %b want 0", stall); end
    sb.push_back(ADD(5'd5, 5'd2, 5'd6));
    step();
    exp_w = sb.pop_front();
    n_vec++; if (ex_word() !== exp_w) begin n_err++; $display("FAIL lu_add_ex: got %h want %h", ex_word(), exp_w); end
    n_vec++; if (stall_cnt !== 16'd1 || s_stall_cnt !== 2'd1) begin
      n_err++; $display("FAIL lu_cnt: got %0d/%0d want 1/1", stall_cnt, s_stall_cnt); end
    n_vec++; if ({fwd_a, fwd_b} !== 4'b0100) begin n_err++; $display("FAIL lu_fwd_wb: got %b want 0100", {fwd_a, fwd_b}); end
    n_vec++; if ({wb_memtoReg, wb_regWrite, wb_rd} !== {1'b1, 1'b1, 5'd5}) begin
      n_err++; $display("FAIL lu_wb: got %h want %h", {wb_memtoReg, wb_regWrite, wb_rd}, {1'b1, 1'b1, 5'd5}); end
    set_id(1'b0, 23'd0);
  endtask

  task automatic test_rd0();
    do_reset();
    set_id(1'b1, LW(5'd3, 5'd0));
    step();
    set_id(1'b1, ADD(5'd0, 5'd4, 5'd8));
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rd0_stall: got %b want 0", stall); end
    sb.push_back(ADD(5'd0, 5'd4, 5'd8));
    step();
    exp_w = sb.pop_front();
    n_vec++; if (ex_word() !== exp_w) begin n_err++; $display("FAIL rd0_ex: got %h want %h", ex_word(), exp_w); end
    n_vec++; if (fwd_a !== 2'b00) begin n_err++; $display("FAIL rd0_fwd_a: got %b want 00", fwd_a); end
    n_vec++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rd0_cnt: got %0d want 0", stall_cnt); end
    set_id(1'b0, 23'd0);
  endtask

  task automatic test_forward();
    do_reset();
    set_id(1'b1, ADD(5'd1, 5'd2, 5'd7)); step();
    set_id(1'b1, ADD(5'd3, 5'd4, 5'd7)); step();
    set_id(1'b1, ADD(5'd7, 5'd7, 5'd9)); sb.push_back(ADD(5'd7, 5'd7, 5'd9));
    step();
    exp_w = sb.pop_front();
    n_vec++; if (ex_word() !== exp_w) begin n_err++; $display("FAIL fw_ex: got %h want %h", ex_word(), exp_w); end
    n_vec++; if ({mem_rd, wb_rd} !== {5'd7, 5'd7}) begin n_err++; $display("FAIL fw_rds: got %h want %h", {mem_rd, wb_rd}, {5'd7, 5'd7}); end
    n_vec++; if ({fwd_a, fwd_b} !== 4'b1010) begin n_err++; $display("FAIL fw_mem_prio: got %b want 1010", {fwd_a, fwd_b}); end
    // MEM now holds rd 9, WB holds rd 7: only rs2 picks up the WB value
    set_id(1'b1, ADD(5'd2, 5'd7, 5'd10)); sb.push_back(ADD(5'd2, 5'd7, 5'd10));
    step();
    exp_w = sb.pop_front();
    n_vec++; if (ex_word() !== exp_w) begin n_err++; $display("FAIL fw_ex2: got %h want %h", ex_word(), exp_w); end
    n_vec++; if ({fwd_a, fwd_b} !== 4'b0001) begin n_err++; $display("FAIL fw_wb_only: got %b want 0001", {fwd_a, fwd_b}); end
    set_id(1'b0, 23'd0);
  endtask

  task automatic test_branch();
    do_reset();
    set_id(1'b1, LW(5'd1, 5'd5)); step();
    set_id(1'b1, BEQ(5'd1, 5'd2)); step();
    set_id(1'b1, ADD(5'd5, 5'd6, 5'd12)); ex_zero = 1'b1;
    #1;
    n_vec++; if ({flush_ifid, stall} !== 2'b10) begin n_err++; $display("FAIL br_flush: got %b want 10", {flush_ifid, stall}); end
    sb.push_back(23'd0);
    step(); ex_zero = 1'b0;
    exp_w = sb.pop_front();
    n_vec++; if (ex_word() !== exp_w) begin n_err++; $display("FAIL br_bubble: got %h want %h", ex_word(), exp_w); end
    n_vec++; if (flush_cnt !== 16'd1) begin n_err++; $display("FAIL br_cnt: got %0d want 1", flush_cnt); end
    // a branch carrying a load of rd 5 with a dependent ID: branch must win
    set_id(1'b1, ins(2'b00, 6'b110001, 5'd0, 5'd0, 5'd5)); step();
    set_id(1'b1, ADD(5'd5, 5'd1, 5'd13)); ex_zero = 1'b1;
    #1;
    n_vec++; if ({flush_ifid, stall} !== 2'b10) begin n_err++; $display("FAIL br_override: got %b want 10", {flush_ifid, stall}); end
    sb.push_back(23'd0);
    step(); ex_zero = 1'b0;
    exp_w = sb.pop_front();
    n_vec++; if (ex_word() !== exp_w) begin n_err++; $display("FAIL br_ovr_bubble: got %h want %h", ex_word(), exp_w); end
    n_vec++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd2) begin
      n_err++; $display("FAIL br_ovr_cnt: got %0d/%0d want 0/2", stall_cnt, flush_cnt); end
    // not taken: no flush, next instruction enters EX
    set_id(1'b1, BEQ(5'd1, 5'd2)); step();
    set_id(1'b1, ADD(5'd3, 5'd4, 5'd14));
    #1;
    n_vec++; if (flush_ifid !== 1'b0) begin n_err++; $display("FAIL br_nt_flush: got %b want 0", flush_ifid); end
    sb.push_back(ADD(5'd3, 5'd4, 5'd14));
    step();
    exp_w = sb.pop_front();
    n_vec++; if (ex_word() !== exp_w) begin n_err++; $display("FAIL br_nt_ex: got %h want %h", ex_word(), exp_w); end
    set_id(1'b0, 23'd0);
  endtask

  task automatic test_saturate();
    int seen;
    seen = 0;
    do_reset();
    set_id(1'b1, LW(5'd0, 5'd5)); step();
    set_id(1'b1, LW(5'd5, 5'd5));
    for (int i = 0; i < 10; i++) begin
      #1;
      if (stall === 1'b1) seen++;
      step();
      if (i == 3) begin
        n_vec++; if (s_stall_cnt !== 2'd2) begin n_err++; $display("FAIL sat_mid: got %0d want 2", s_stall_cnt); end
      end
    end
    n_vec++; if (seen != 5) begin n_err++; $display("FAIL sat_events: got %0d want 5", seen); end
    n_vec++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL sat_wide: got %0d want 5", stall_cnt); end
    n_vec++; if (s_stall_cnt !== 2'd3) begin n_err++; $display("FAIL sat_narrow: got %0d want 3", s_stall_cnt); end
    // reset in the middle of the hazard stream
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++; if (stall_cnt !== 16'd0 || s_stall_cnt !== 2'd0 || flush_cnt !== 16'd0) begin
      n_err++; $display("FAIL sat_rst_cnt: got %0d/%0d/%0d want 0/0/0", stall_cnt, s_stall_cnt, flush_cnt); end
    n_vec++; if ({ex_word(), mem_memRead, mem_regWrite, mem_rd, wb_regWrite, wb_rd} !== 41'd0) begin
      n_err++; $display("FAIL sat_rst_pipe: got %h want 0", {ex_word(), mem_memRead, mem_regWrite, mem_rd, wb_regWrite, wb_rd}); end
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL sat_rst_stall: got %b want 0", stall); end
    set_id(1'b0, 23'd0);
  endtask

  initial begin
    reset = 1'b1;
    ex_zero = 1'b0;
    set_id(1'b0, 23'd0);
    test_reset();
    test_load_use();
    test_rd0();
    test_forward();
    test_branch();
    test_saturate();
    if (sb.size() != 0) begin
      n_err++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
